// File: rtl/pipeline_control_ldst_responder.sv
// Load/store responder for the pipeline-control sequencers: one request -> one word-aligned memory access.
// Optional misalignment faulting is enabled by defining PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN.
module pipeline_control_ldst_responder #(
  parameter int P_ADDR_W = 32
) (
  input  logic                iCLOCK,
  input  logic                iRESET,
  input  logic                iRESET_SYNC,
  input  logic                iLDST_USE,
  input  logic                iLDST_REQ,
  output logic                oLDST_BUSY,
  input  logic [1:0]          iLDST_ORDER,
  input  logic                iLDST_RW,
  input  logic [P_ADDR_W-1:0] iLDST_ADDR,
  input  logic [31:0]         iLDST_DATA,
  output logic                oLDST_REQ,
  output logic [31:0]         oLDST_DATA,
  output logic                oLDST_FAULT,
  output logic                oMEM_REQ,
  input  logic                iMEM_BUSY,
  output logic                oMEM_RW,
  output logic [P_ADDR_W-1:0] oMEM_ADDR,
  output logic [3:0]          oMEM_MASK,
  output logic [31:0]         oMEM_DATA,
  input  logic                iMEM_VALID,
  input  logic [31:0]         iMEM_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  localparam logic [1:0] ORDER_BYTE = 2'b00;
  localparam logic [1:0] ORDER_HALF = 2'b01;
  localparam logic [1:0] ORDER_WORD = 2'b10;
  localparam logic [1:0] ORDER_NONE = 2'b11;

  state_t                state_r;
  logic                  busy_r;
  logic                  ldst_req_r;
  logic                  fault_r;
  logic [31:0]           ldst_data_r;
  logic                  mem_req_r;
  logic                  mem_rw_r;
  logic [P_ADDR_W-1:0]   mem_addr_r;
  logic [3:0]            mem_mask_r;
  logic [31:0]           mem_data_r;
  logic [1:0]            order_r;
  logic [1:0]            addr_lo_r;
  logic                  accept_s;
  logic                  misaligned_s;

  // Big-endian lane enables: byte offset 0 is bits [31:24].
  function automatic logic [3:0] lane_mask(input logic [1:0] order, input logic [1:0] lo);
    logic [3:0] mask;
    case (order)
      ORDER_BYTE: mask = 4'b1000 >> lo;
      ORDER_HALF: mask = lo[1] ? 4'b0011 : 4'b1100;
      ORDER_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] order, input logic [31:0] d);
    logic [31:0] w;
    case (order)
      ORDER_BYTE: w = {4{d[7:0]}};
      ORDER_HALF: w = {2{d[15:0]}};
      default:    w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] order, input logic [1:0] lo,
                                               input logic [31:0] w);
    logic [31:0] r;
    case (order)
      ORDER_BYTE: begin
        case (lo)
          2'd0:    r = {24'h000000, w[31:24]};
          2'd1:    r = {24'h000000, w[23:16]};
          2'd2:    r = {24'h000000, w[15:8]};
          default: r = {24'h000000, w[7:0]};
        endcase
      end
      ORDER_HALF: r = lo[1] ? {16'h0000, w[15:0]} : {16'h0000, w[31:16]};
      default:    r = w;
    endcase
    return r;
  endfunction

  // Request acceptance and misalignment detection.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && iLDST_USE && iLDST_REQ;
`ifdef PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN
    misaligned_s = ((iLDST_ORDER == ORDER_HALF) && iLDST_ADDR[0]) ||
                   ((iLDST_ORDER == ORDER_WORD) && (iLDST_ADDR[1:0] != 2'b00));
`else
    misaligned_s = 1'b0;
`endif
  end

  // Responder FSM with all outputs registered.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      ldst_req_r  <= 1'b0;
      fault_r     <= 1'b0;
      ldst_data_r <= 32'h00000000;
      mem_req_r   <= 1'b0;
      mem_rw_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_mask_r  <= 4'b0000;
      mem_data_r  <= 32'h00000000;
      order_r     <= 2'b00;
      addr_lo_r   <= 2'b00;
    end else if (iRESET_SYNC) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      ldst_req_r  <= 1'b0;
      fault_r     <= 1'b0;
      ldst_data_r <= 32'h00000000;
      mem_req_r   <= 1'b0;
      mem_rw_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_mask_r  <= 4'b0000;
      mem_data_r  <= 32'h00000000;
      order_r     <= 2'b00;
      addr_lo_r   <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ldst_req_r <= 1'b0;
          fault_r    <= 1'b0;
          if (accept_s) begin
            busy_r    <= 1'b1;
            order_r   <= iLDST_ORDER;
            addr_lo_r <= iLDST_ADDR[1:0];
            mem_rw_r  <= iLDST_RW;
            // No-op orders and faulting accesses answer immediately without touching memory.
            if ((iLDST_ORDER == ORDER_NONE) || misaligned_s) begin
              state_r     <= ST_RESP;
              ldst_req_r  <= 1'b1;
              fault_r     <= misaligned_s;
              ldst_data_r <= 32'h00000000;
            end else begin
              state_r    <= ST_MEM_REQ;
              mem_req_r  <= 1'b1;
              mem_addr_r <= {iLDST_ADDR[P_ADDR_W-1:2], 2'b00};
              mem_mask_r <= lane_mask(iLDST_ORDER, iLDST_ADDR[1:0]);
              mem_data_r <= lane_wdata(iLDST_ORDER, iLDST_DATA);
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_MEM_REQ: begin
          if (!iMEM_BUSY) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_MEM_WAIT;
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (iMEM_VALID) begin
            state_r     <= ST_RESP;
            ldst_req_r  <= 1'b1;
            ldst_data_r <= mem_rw_r ? 32'h00000000 : lane_extract(order_r, addr_lo_r, iMEM_DATA);
          end else begin
            ldst_req_r <= 1'b0;
          end
        end
        ST_RESP: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          ldst_req_r <= 1'b0;
          fault_r    <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          ldst_req_r <= 1'b0;
          mem_req_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oLDST_BUSY  = busy_r;
  assign oLDST_REQ   = ldst_req_r;
  assign oLDST_DATA  = ldst_data_r;
  assign oLDST_FAULT = fault_r;
  assign oMEM_REQ    = mem_req_r;
  assign oMEM_RW     = mem_rw_r;
  assign oMEM_ADDR   = mem_addr_r;
  assign oMEM_MASK   = mem_mask_r;
  assign oMEM_DATA   = mem_data_r;

endmodule

// File: tb/tb_pipeline_control_ldst_responder.sv
// Self-checking bench for pipeline_control_ldst_responder: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_pipeline_control_ldst_responder;

  logic        iCLOCK = 1'b0;
  logic        iRESET, iRESET_SYNC, iLDST_USE, iLDST_REQ, iLDST_RW;
  logic [1:0]  iLDST_ORDER;
  logic [31:0] iLDST_ADDR, iLDST_DATA;
  logic        oLDST_BUSY, oLDST_REQ, oLDST_FAULT, oMEM_REQ, oMEM_RW;
  logic [31:0] oLDST_DATA, oMEM_ADDR, oMEM_DATA;
  logic [3:0]  oMEM_MASK;
  logic        iMEM_BUSY, iMEM_VALID;
  logic [31:0] iMEM_DATA;

  int errors = 0;
  int checks = 0;

  pipeline_control_ldst_responder #(.P_ADDR_W(32)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
    .iLDST_USE(iLDST_USE), .iLDST_REQ(iLDST_REQ), .oLDST_BUSY(oLDST_BUSY),
    .iLDST_ORDER(iLDST_ORDER), .iLDST_RW(iLDST_RW), .iLDST_ADDR(iLDST_ADDR),
    .iLDST_DATA(iLDST_DATA), .oLDST_REQ(oLDST_REQ), .oLDST_DATA(oLDST_DATA),
    .oLDST_FAULT(oLDST_FAULT), .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY),
    .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR), .oMEM_MASK(oMEM_MASK),
    .oMEM_DATA(oMEM_DATA), .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  // Reference model: plain arithmetic on byte offsets.
  function automatic logic [3:0] m_mask(input logic [1:0] o, input logic [31:0] a);
    int unsigned off = a % 4;
    if (o == 2'd0) return 4'(1 << (3 - off));
    if (o == 2'd1) return (((a / 2) % 2) == 1) ? 4'd3 : 4'd12;
    if (o == 2'd2) return 4'd15;
    return 4'd0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] o, input logic [31:0] d);
    if (o == 2'd0) return (d % 256) * 32'h01010101;
    if (o == 2'd1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] o, input logic [31:0] a, input logic [31:0] w);
    if (o == 2'd0) return (w >> (8 * (3 - (a % 4)))) % 256;
    if (o == 2'd1) return (w >> (16 * (1 - ((a / 2) % 2)))) % 65536;
    return w;
  endfunction

  function automatic logic m_misaligned(input logic [1:0] o, input logic [31:0] a);
`ifdef PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN
    return ((o == 2'd1) && (a % 2 != 0)) || ((o == 2'd2) && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic present(input logic [1:0] o, input logic rw, input logic [31:0] a, input logic [31:0] d);
    iLDST_USE = 1'b1; iLDST_REQ = 1'b1; iLDST_ORDER = o; iLDST_RW = rw;
    iLDST_ADDR = a; iLDST_DATA = d;
  endtask

  task automatic test_reset();
    iRESET = 1'b1; iRESET_SYNC = 1'b0; iLDST_USE = 1'b0; iLDST_REQ = 1'b0;
    iLDST_ORDER = 2'd0; iLDST_RW = 1'b0; iLDST_ADDR = 32'h0; iLDST_DATA = 32'h0;
    iMEM_BUSY = 1'b0; iMEM_VALID = 1'b0; iMEM_DATA = 32'h0;
    step(); step();
    iRESET = 1'b0;
    step();
    checks++;
    if ({oLDST_BUSY, oLDST_REQ, oLDST_FAULT, oMEM_REQ, oMEM_RW} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {oLDST_BUSY, oLDST_REQ, oLDST_FAULT, oMEM_REQ, oMEM_RW});
    end
    checks++;
    if ({oLDST_DATA, oMEM_ADDR, oMEM_DATA, oMEM_MASK} !== 100'h0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", oLDST_DATA, oMEM_ADDR, oMEM_DATA, oMEM_MASK);
    end
    // USE low must block a request.
    iLDST_USE = 1'b0; iLDST_REQ = 1'b1;
    step();
    iLDST_REQ = 1'b0;
    checks++;
    if ({oLDST_BUSY, oMEM_REQ} !== 2'b00) begin
      errors++; $display("FAIL use_gate got busy=%b memreq=%b want 0 0", oLDST_BUSY, oMEM_REQ);
    end
  endtask

  task automatic test_word_read();
    present(2'd2, 1'b0, 32'h100, 32'h0);
    step();                                  // N+1
    iLDST_REQ = 1'b0;
    checks++;
    if ({oMEM_REQ, oLDST_BUSY, oMEM_RW, oMEM_ADDR, oMEM_MASK} !== {3'b110, 32'h100, 4'hF}) begin
      errors++; $display("FAIL word_rd_mem got req=%b busy=%b rw=%b addr=%h mask=%b want 1 1 0 100 1111",
                         oMEM_REQ, oLDST_BUSY, oMEM_RW, oMEM_ADDR, oMEM_MASK);
    end
    step();                                  // N+2
    iMEM_VALID = 1'b1; iMEM_DATA = 32'hDEADBEEF;
    step();                                  // N+3
    iMEM_VALID = 1'b0;
    checks++;
    if ({oLDST_REQ, oLDST_FAULT, oLDST_DATA} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL word_rd_resp got req=%b fault=%b data=%h want 1 0 deadbeef", oLDST_REQ, oLDST_FAULT, oLDST_DATA);
    end
    step();                                  // N+4
    checks++;
    if ({oLDST_BUSY, oLDST_REQ, oLDST_DATA} !== {2'b00, 32'hDEADBEEF}) begin
      errors++; $display("FAIL word_rd_idle got busy=%b req=%b data=%h want 0 0 deadbeef", oLDST_BUSY, oLDST_REQ, oLDST_DATA);
    end
  endtask

  task automatic test_byte_half_read();
    logic [1:0]  ords [2] = '{2'd0, 2'd1};
    logic [31:0] adrs [2] = '{32'h103, 32'h102};
    logic [3:0]  msks [2] = '{4'b0001, 4'b0011};
    logic [31:0] exps [2] = '{32'h00000044, 32'h00003344};
    for (int i = 0; i < 2; i++) begin
      present(ords[i], 1'b0, adrs[i], 32'h0);
      step();
      iLDST_REQ = 1'b0;
      checks++;
      if ({oMEM_REQ, oMEM_ADDR, oMEM_MASK} !== {1'b1, 32'h100, msks[i]}) begin
        errors++; $display("FAIL narrow_rd_mask[%0d] got req=%b addr=%h mask=%b want 1 100 %b", i, oMEM_REQ, oMEM_ADDR, oMEM_MASK, msks[i]);
      end
      step();
      iMEM_VALID = 1'b1; iMEM_DATA = 32'h11223344;
      step();
      iMEM_VALID = 1'b0;
      checks++;
      if ({oLDST_REQ, oLDST_DATA} !== {1'b1, exps[i]}) begin
        errors++; $display("FAIL narrow_rd_data[%0d] got req=%b data=%h want 1 %h", i, oLDST_REQ, oLDST_DATA, exps[i]);
      end
      step();
    end
  endtask

  task automatic test_byte_write_stall();
    present(2'd0, 1'b1, 32'h101, 32'h000000A5);
    step();
    iLDST_REQ = 1'b0; iMEM_BUSY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) iMEM_BUSY = 1'b0;
      checks++;
      if ({oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA} !== {2'b11, 32'h100, 4'b0100, 32'hA5A5A5A5}) begin
        errors++; $display("FAIL wr_stall[%0d] got req=%b rw=%b addr=%h mask=%b data=%h want 1 1 100 0100 a5a5a5a5",
                           c, oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA);
      end
      step();
    end
    checks++;
    if ({oMEM_REQ, oLDST_BUSY} !== 2'b01) begin
      errors++; $display("FAIL wr_wait got memreq=%b busy=%b want 0 1", oMEM_REQ, oLDST_BUSY);
    end
    iMEM_VALID = 1'b1; iMEM_DATA = 32'hFFFFFFFF;
    step();
    iMEM_VALID = 1'b0;
    checks++;
    if ({oLDST_REQ, oLDST_DATA} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wr_ack got req=%b data=%h want 1 00000000", oLDST_REQ, oLDST_DATA);
    end
    step();
  endtask

  task automatic test_busy_drop();
    present(2'd2, 1'b0, 32'h200, 32'h0);
    step();                                  // MEM_REQ
    iLDST_ADDR = 32'h400; iMEM_BUSY = 1'b1; iMEM_VALID = 1'b1; iMEM_DATA = 32'h0BADF00D;
    step();                                  // still MEM_REQ
    checks++;
    if ({oMEM_REQ, oMEM_ADDR, oLDST_REQ} !== {1'b1, 32'h200, 1'b0}) begin
      errors++; $display("FAIL drop_memreq got req=%b addr=%h resp=%b want 1 200 0", oMEM_REQ, oMEM_ADDR, oLDST_REQ);
    end
    iMEM_BUSY = 1'b0; iMEM_VALID = 1'b0;
    step();                                  // MEM_WAIT
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h12345678;
    step();                                  // RESP, iLDST_REQ still high
    iMEM_VALID = 1'b0;
    checks++;
    if ({oLDST_REQ, oLDST_DATA} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL drop_resp got req=%b data=%h want 1 12345678", oLDST_REQ, oLDST_DATA);
    end
    step();                                  // IDLE: request seen during RESP dropped
    iLDST_REQ = 1'b0;
    checks++;
    if ({oLDST_BUSY, oMEM_REQ, oLDST_REQ} !== 3'b000) begin
      errors++; $display("FAIL drop_idle got busy=%b memreq=%b resp=%b want 0 0 0", oLDST_BUSY, oMEM_REQ, oLDST_REQ);
    end
    step();
    checks++;
    if ({oLDST_BUSY, oMEM_REQ, oLDST_REQ} !== 3'b000) begin
      errors++; $display("FAIL drop_quiet got busy=%b memreq=%b resp=%b want 0 0 0", oLDST_BUSY, oMEM_REQ, oLDST_REQ);
    end
  endtask

  task automatic test_sync_abort();
    logic [31:0] exp;
    present(2'd2, 1'b0, 32'h300, 32'h0);
    step();
    iLDST_REQ = 1'b0;
    step();                                  // MEM_WAIT
    iRESET_SYNC = 1'b1;
    step();
    iRESET_SYNC = 1'b0; iMEM_VALID = 1'b1; iMEM_DATA = 32'h55555555;
    checks++;
    if ({oLDST_BUSY, oMEM_REQ, oLDST_REQ, oLDST_DATA} !== 35'h0) begin
      errors++; $display("FAIL abort_idle got busy=%b memreq=%b resp=%b data=%h want 0 0 0 0", oLDST_BUSY, oMEM_REQ, oLDST_REQ, oLDST_DATA);
    end
    step();
    iMEM_VALID = 1'b0;
    checks++;
    if ({oLDST_BUSY, oLDST_REQ} !== 2'b00) begin
      errors++; $display("FAIL abort_stale got busy=%b resp=%b want 0 0", oLDST_BUSY, oLDST_REQ);
    end
    present(2'd0, 1'b0, 32'h302, 32'h0);
    step();
    iLDST_REQ = 1'b0;
    step();
    iMEM_VALID = 1'b1; iMEM_DATA = 32'hCAFEF00D;
    exp = m_rdata(2'd0, 32'h302, 32'hCAFEF00D);
    step();
    iMEM_VALID = 1'b0;
    checks++;
    if ({oLDST_REQ, oLDST_DATA} !== {1'b1, exp}) begin
      errors++; $display("FAIL abort_next got req=%b data=%h want 1 %h", oLDST_REQ, oLDST_DATA, exp);
    end
    step();
  endtask

  task automatic test_order_none();
    present(2'd3, 1'($urandom_range(0, 1)), 32'h12345677, $urandom);
    step();
    iLDST_REQ = 1'b0;
    checks++;
    if ({oLDST_REQ, oLDST_BUSY, oLDST_FAULT, oMEM_REQ, oLDST_DATA} !== {4'b1100, 32'h0}) begin
      errors++; $display("FAIL none_resp got req=%b busy=%b fault=%b memreq=%b data=%h want 1 1 0 0 0",
                         oLDST_REQ, oLDST_BUSY, oLDST_FAULT, oMEM_REQ, oLDST_DATA);
    end
    step();
  endtask

  task automatic test_misaligned_word();
    present(2'd2, 1'b0, 32'h102, 32'h0);
    step();
    iLDST_REQ = 1'b0;
`ifdef PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN
    checks++;
    if ({oLDST_REQ, oLDST_FAULT, oMEM_REQ, oLDST_DATA} !== {3'b110, 32'h0}) begin
      errors++; $display("FAIL misalign_fault got req=%b fault=%b memreq=%b data=%h want 1 1 0 0", oLDST_REQ, oLDST_FAULT, oMEM_REQ, oLDST_DATA);
    end
    step();
    checks++;
    if ({oLDST_REQ, oLDST_FAULT, oLDST_BUSY} !== 3'b000) begin
      errors++; $display("FAIL misalign_clear got req=%b fault=%b busy=%b want 0 0 0", oLDST_REQ, oLDST_FAULT, oLDST_BUSY);
    end
`else
    checks++;
    if ({oMEM_REQ, oMEM_ADDR, oMEM_MASK, oLDST_REQ} !== {1'b1, 32'h100, 4'hF, 1'b0}) begin
      errors++; $display("FAIL misalign_mem got req=%b addr=%h mask=%b resp=%b want 1 100 1111 0", oMEM_REQ, oMEM_ADDR, oMEM_MASK, oLDST_REQ);
    end
    step();
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h01020304;
    step();
    iMEM_VALID = 1'b0;
    checks++;
    if ({oLDST_REQ, oLDST_FAULT, oLDST_DATA} !== {2'b10, 32'h01020304}) begin
      errors++; $display("FAIL misalign_resp got req=%b fault=%b data=%h want 1 0 01020304", oLDST_REQ, oLDST_FAULT, oLDST_DATA);
    end
    step();
`endif
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic        rw, mis;
    logic [31:0] a, d, w, exp_data;
    int          stall, delay;
    for (int t = 0; t < 60; t++) begin
      o = 2'($urandom_range(0, 3)); rw = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; w = $urandom;
      stall = $urandom_range(0, 3); delay = $urandom_range(0, 2);
      mis = m_misaligned(o, a);
      present(o, rw, a, d);
      step();
      iLDST_REQ = 1'b0;
      if (o == 2'd3 || mis) begin
        checks++;
        if ({oLDST_REQ, oLDST_FAULT, oMEM_REQ, oLDST_DATA} !== {1'b1, mis, 1'b0, 32'h0}) begin
          errors++; $display("FAIL rnd_direct[%0d] got req=%b fault=%b memreq=%b data=%h want 1 %b 0 0",
                             t, oLDST_REQ, oLDST_FAULT, oMEM_REQ, oLDST_DATA, mis);
        end
        step();
        continue;
      end
      for (int s = 0; s <= stall; s++) begin
        iMEM_BUSY = (s < stall);
        checks++;
        if ({oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_MASK} !== {1'b1, rw, (a / 4) * 4, m_mask(o, a)} ||
            (rw && (oMEM_DATA !== m_wdata(o, d)))) begin
          errors++; $display("FAIL rnd_mem[%0d] got req=%b rw=%b addr=%h mask=%b data=%h want 1 %b %h %b %h",
                             t, oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA, rw, (a / 4) * 4, m_mask(o, a), m_wdata(o, d));
        end
        step();
      end
      iMEM_BUSY = 1'b0;
      for (int k = 0; k < delay; k++) step();
      checks++;
      if ({oMEM_REQ, oLDST_BUSY, oLDST_REQ} !== 3'b010) begin
        errors++; $display("FAIL rnd_wait[%0d] got memreq=%b busy=%b resp=%b want 0 1 0", t, oMEM_REQ, oLDST_BUSY, oLDST_REQ);
      end
      iMEM_VALID = 1'b1; iMEM_DATA = w;
      step();
      iMEM_VALID = 1'b0;
      exp_data = rw ? 32'h0 : m_rdata(o, a, w);
      checks++;
      if ({oLDST_REQ, oLDST_FAULT, oLDST_DATA} !== {2'b10, exp_data}) begin
        errors++; $display("FAIL rnd_resp[%0d] got req=%b fault=%b data=%h want 1 0 %h", t, oLDST_REQ, oLDST_FAULT, oLDST_DATA, exp_data);
      end
      step();
      checks++;
      if ({oLDST_REQ, oLDST_BUSY, oLDST_DATA} !== {2'b00, exp_data}) begin
        errors++; $display("FAIL rnd_hold[%0d] got req=%b busy=%b data=%h want 0 0 %h", t, oLDST_REQ, oLDST_BUSY, oLDST_DATA, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_half_read();
    test_byte_write_stall();
    test_busy_drop();
    test_sync_abort();
    test_order_none();
    test_misaligned_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_control_ldst_responder.md
Name: pipeline_control_ldst_responder

Overview:
- Responder end of the pipeline-control load/store port used by the IRQ-call, handler-read and SPR-exchange sequencers.
- Accepts one request at a time and converts it into a word-aligned memory bus access with byte lanes.
- Returns right-justified read data, or a write acknowledge, as a one-cycle response pulse.
- Sits between the pipeline-control sequencers and the core's data-memory arbiter.

Parameters:
- P_ADDR_W, 32, address width of upstream and memory address buses.

Ports:
- iCLOCK  in  1  single clock, all logic posedge.
- iRESET  in  1  asynchronous, active-high reset.
- iRESET_SYNC  in  1  synchronous clear, same effect as iRESET.
- iLDST_USE  in  1  requester owns the port; iLDST_REQ is ignored while low.
- iLDST_REQ  in  1  request strobe.
- oLDST_BUSY  out  1  responder cannot accept a request.
- iLDST_ORDER  in  2  00=byte, 01=halfword, 10=word, 11=none.
- iLDST_RW  in  1  0=read, 1=write.
- iLDST_ADDR  in  P_ADDR_W  byte address.
- iLDST_DATA  in  32  write data, right-justified.
- oLDST_REQ  out  1  response valid, one-cycle pulse.
- oLDST_DATA  out  32  read data, zero-extended and right-justified; 0 for writes.
- oLDST_FAULT  out  1  misalignment fault, qualified by oLDST_REQ.
- oMEM_REQ  out  1  memory request.
- iMEM_BUSY  in  1  memory stall; request is taken in a cycle with oMEM_REQ=1 and iMEM_BUSY=0.
- oMEM_RW  out  1  0=read, 1=write.
- oMEM_ADDR  out  P_ADDR_W  word address, bits [1:0]=0.
- oMEM_MASK  out  4  byte-lane enable; bit3 = bits[31:24].
- oMEM_DATA  out  32  lane-replicated write data.
- iMEM_VALID  in  1  read data or write acknowledge, one cycle.
- iMEM_DATA  in  32  read word.

Behaviour:
- Reset (iRESET or iRESET_SYNC):
  - State goes to IDLE.
  - All outputs 0, oLDST_BUSY=0.
  - Captured request fields cleared.
- Accept:
  - Condition: state IDLE and iLDST_USE and iLDST_REQ.
  - Captures ORDER, RW, ADDR, DATA.
  - oLDST_BUSY is high in every state except IDLE.
  - Requests presented while busy are dropped; the requester must wait for BUSY low.
- States:
  - IDLE: on accept, go to MEM_REQ; if ORDER=11, go to RESP.
  - MEM_REQ: oMEM_REQ=1 with stable RW/ADDR/MASK/DATA; when iMEM_BUSY=0, go to MEM_WAIT.
  - MEM_WAIT: on iMEM_VALID, latch lane-extracted data (writes latch 0) and go to RESP.
  - RESP: oLDST_REQ=1 for exactly one cycle, then IDLE. oLDST_DATA holds its value until the next RESP.
- Memory lanes (big-endian; byte at addr[1:0]=0 is bits[31:24]):
  - Byte: MASK = 4'b1000 >> addr[1:0]; write data {4{d[7:0]}}.
  - Halfword: MASK = addr[1] ? 0011 : 1100; write data {2{d[15:0]}}.
  - Word: MASK = 1111.
- Read extraction:
  - Byte: selected lane, zero-extended.
  - Halfword: selected half, zero-extended.
  - Word: unchanged.
- Latency:
  - Accept at cycle N; oMEM_REQ high from N+1.
  - With no stall and iMEM_VALID at N+2, oLDST_REQ fires at N+3.
  - ORDER=11: oLDST_REQ at N+1, data 0, no memory access.
- Boundaries:
  - iMEM_VALID outside MEM_WAIT is ignored.
  - iMEM_BUSY held high keeps MEM_REQ indefinitely, with outputs stable.
  - iRESET_SYNC mid-operation aborts to IDLE, and no response is issued.
  - A stale iMEM_VALID after an abort is ignored.
  - iLDST_REQ arriving in the same cycle as RESP is dropped, because BUSY is still high.

Optional Feature:
- Macro: PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN.
- Defined:
  - Misaligned accesses are halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access skips memory and goes IDLE -> RESP.
  - The response is oLDST_REQ=1, oLDST_FAULT=1, oLDST_DATA=0 at N+1.
- Undefined:
  - No alignment check; halfword ignores addr[0] and word ignores addr[1:0].
  - oLDST_FAULT is tied 0.

Test Plan:
- Word read at addr 0x100, iMEM_DATA=0xDEADBEEF returned at N+2 -> oMEM_ADDR=0x100, MASK=1111 at N+1; oLDST_REQ with DATA=0xDEADBEEF at N+3; BUSY low at N+4.
- Byte read at addr 0x103, iMEM_DATA=0x11223344 -> MASK=0001; oLDST_DATA=0x00000044. Halfword read at 0x102 -> MASK=0011; oLDST_DATA=0x00003344.
- Byte write at 0x101 with data 0x000000A5, iMEM_BUSY high for 3 cycles -> oMEM_REQ held 4 cycles with MASK=0100 and oMEM_DATA=0xA5A5A5A5 stable; after ack, oLDST_REQ=1 with DATA=0.
- Second iLDST_REQ while BUSY, plus stray iMEM_VALID during MEM_REQ -> both ignored; exactly one memory access and one response.
- iRESET_SYNC in MEM_WAIT, then iMEM_VALID the next cycle -> state IDLE, no oLDST_REQ, next request served normally.
- Word read at 0x102: with PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN -> oLDST_REQ and oLDST_FAULT at N+1, no oMEM_REQ; without the macro -> oMEM_ADDR=0x100, MASK=1111, FAULT=0.
